// File: rtl/vga_timing_pattern.sv
// -----------------------------------------------------------------------------
// vga_timing_pattern
//   VGA timing generator with a runtime-selectable test-pattern engine. Runs in
//   the pixel clock domain and produces registered colour, sync and blank
//   signals for vga2dvid. It also reports pixel coordinates and a frame counter,
//   and gives a one-cycle strobe on pixel (0,0).
//
// Ports:
//   clk_pixel    in   pixel clock
//   reset        in   asynchronous, active-high
//   enable       in   1 = pattern, 0 = black active video (sampled per frame)
//   pattern_sel  in   0 bars, 1 checker, 2 gradient, 3 bouncing box
//   vga_r/g/b    out  8-bit colour components (0 while blanked)
//   vga_hsync    out  horizontal sync at C_hsync_polarity when asserted
//   vga_vsync    out  vertical sync at C_vsync_polarity when asserted
//   vga_blank    out  1 outside the active area
//   x, y         out  coordinates of the pixel currently on the outputs
//   frame_start  out  one-cycle pulse together with pixel (0,0)
//   frame_count  out  frames completed since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_timing_pattern #(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter bit C_hsync_polarity    = 1'b0,
    parameter bit C_vsync_polarity    = 1'b0,
    parameter int C_check_log2        = 4,
    parameter int C_box               = 32,
    parameter int C_bits_x            = 12,
    parameter int C_bits_y            = 11
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          pattern_sel,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_blank,
    output logic [C_bits_x-1:0] x,
    output logic [C_bits_y-1:0] y,
    output logic                frame_start,
    output logic [7:0]          frame_count
);

    typedef enum logic [1:0] {PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_BOX} pattern_e;

    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;

    localparam logic [C_bits_x-1:0] H_LAST    = C_bits_x'(H_TOTAL - 1);
    localparam logic [C_bits_x-1:0] H_ACT     = C_bits_x'(C_resolution_x);
    localparam logic [C_bits_x-1:0] H_SS      = C_bits_x'(C_resolution_x + C_hsync_front_porch);
    localparam logic [C_bits_x-1:0] H_SE      = C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [C_bits_x-1:0] BAR_LAST  = C_bits_x'(C_resolution_x / 8 - 1);
    localparam logic [C_bits_x-1:0] BOX_X     = C_bits_x'(C_box);
    localparam logic [C_bits_x-1:0] BOX_MAX_X = C_bits_x'(C_resolution_x - C_box);
    localparam logic [C_bits_x-1:0] ONE_X     = C_bits_x'(1);

    localparam logic [C_bits_y-1:0] V_LAST    = C_bits_y'(V_TOTAL - 1);
    localparam logic [C_bits_y-1:0] V_ACT     = C_bits_y'(C_resolution_y);
    localparam logic [C_bits_y-1:0] V_SS      = C_bits_y'(C_resolution_y + C_vsync_front_porch);
    localparam logic [C_bits_y-1:0] V_SE      = C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic [C_bits_y-1:0] BOX_Y     = C_bits_y'(C_box);
    localparam logic [C_bits_y-1:0] BOX_MAX_Y = C_bits_y'(C_resolution_y - C_box);
    localparam logic [C_bits_y-1:0] ONE_Y     = C_bits_y'(1);

    // Raster and per-frame state
    logic [C_bits_x-1:0] cx_q, cx_d;
    logic [C_bits_y-1:0] cy_q, cy_d;
    logic [C_bits_x-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    logic                first_q, first_d;
    logic [7:0]          fc_q, fc_d;
    pattern_e            pat_q, pat_d;
    logic                en_q, en_d;
    logic [C_bits_x-1:0] bx_q, bx_d;
    logic [C_bits_y-1:0] by_q, by_d;
    logic                bx_neg_q, bx_neg_d;   // 1 = box moving towards x = 0
    logic                by_neg_q, by_neg_d;

    // Registered outputs
    logic [23:0]         rgb_q, rgb_d;
    logic                hs_q, vs_q, blank_q, fs_q;
    logic [C_bits_x-1:0] x_q;
    logic [C_bits_y-1:0] y_q;

    logic frame_edge, active, hs_on, vs_on, in_box;

    assign frame_edge = (cx_q == '0) && (cy_q == '0);
    assign active     = (cx_q < H_ACT) && (cy_q < V_ACT);
    assign hs_on      = (cx_q >= H_SS) && (cx_q < H_SE);
    assign vs_on      = (cy_q >= V_SS) && (cy_q < V_SE);

    // Next-state for raster, bar tracker and per-frame state. The *_d values
    // of the per-frame registers are the ones in force for the current frame,
    // so pixel (0,0) already sees the freshly sampled pattern, count and box.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        cx_d      = cx_q + ONE_X;
        cy_d      = cy_q;
        bar_cnt_d = bar_cnt_q + ONE_X;
        bar_idx_d = bar_idx_q;
        first_d   = first_q;
        fc_d      = fc_q;
        pat_d     = pat_q;
        en_d      = en_q;
        bx_d      = bx_q;
        by_d      = by_q;
        bx_neg_d  = bx_neg_q;
        by_neg_d  = by_neg_q;

        if (cx_q == H_LAST) begin
            cx_d      = '0;
            cy_d      = (cy_q == V_LAST) ? '0 : cy_q + ONE_Y;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        if (frame_edge) begin
            pat_d   = pattern_e'(pattern_sel);
            en_d    = enable;
            first_d = 1'b0;
            // The first frame after reset shows count 0 and the box at (0,0).
            if (!first_q) begin
                fc_d = fc_q + 8'd1;
                if (!bx_neg_q) begin
                    if (bx_q == BOX_MAX_X) begin bx_neg_d = 1'b1; bx_d = bx_q - ONE_X; end
                    else                          bx_d = bx_q + ONE_X;
                end else begin
                    if (bx_q == '0) begin bx_neg_d = 1'b0; bx_d = bx_q + ONE_X; end
                    else                   bx_d = bx_q - ONE_X;
                end
                if (!by_neg_q) begin
                    if (by_q == BOX_MAX_Y) begin by_neg_d = 1'b1; by_d = by_q - ONE_Y; end
                    else                          by_d = by_q + ONE_Y;
                end else begin
                    if (by_q == '0) begin by_neg_d = 1'b0; by_d = by_q + ONE_Y; end
                    else                   by_d = by_q - ONE_Y;
                end
            end
        end
    end

    assign in_box = (cx_q >= bx_d) && (cx_q < bx_d + BOX_X) &&
                    (cy_q >= by_d) && (cy_q < by_d + BOX_Y);

    // Pixel colour for the current raster position.
    always_comb begin
        rgb_d = '0;
        if (active && en_d) begin
            unique case (pat_d)
                // White, yellow, cyan, green, magenta, red, blue, black:
                // each component is an inverted bit of the bar index.
                PAT_BARS:  rgb_d = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
                PAT_CHECK: rgb_d = (cx_q[C_check_log2] ^ cy_q[C_check_log2]) ? 24'hFFFFFF : 24'h000000;
                PAT_GRAD:  rgb_d = {cx_q[7:0], cy_q[7:0], fc_d};
                PAT_BOX:   rgb_d = in_box ? 24'hFFFFFF : 24'h000080;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cx_q      <= '0;
            cy_q      <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            first_q   <= 1'b1;
            fc_q      <= '0;
            pat_q     <= PAT_BARS;
            en_q      <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            bx_neg_q  <= 1'b0;
            by_neg_q  <= 1'b0;
            rgb_q     <= '0;
            hs_q      <= ~C_hsync_polarity;
            vs_q      <= ~C_vsync_polarity;
            blank_q   <= 1'b1;
            fs_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            first_q   <= first_d;
            fc_q      <= fc_d;
            pat_q     <= pat_d;
            en_q      <= en_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            bx_neg_q  <= bx_neg_d;
            by_neg_q  <= by_neg_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_on ? C_hsync_polarity : ~C_hsync_polarity;
            vs_q      <= vs_on ? C_vsync_polarity : ~C_vsync_polarity;
            blank_q   <= ~active;
            fs_q      <= frame_edge;
            x_q       <= cx_q;
            y_q       <= cy_q;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_blank   = blank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_pattern
//   Drives two 16x8 instances (sync polarity 0 and 1) with shared stimulus and
//   compares every output on every cycle against a frame-level reference model
//   built from raster position, frame index and closed-form colour rules.
// -----------------------------------------------------------------------------
module tb_vga_timing_pattern;

    localparam int RX  = 16;
    localparam int RY  = 8;
    localparam int HT  = 24;
    localparam int VT  = 12;
    localparam int HSS = 18;   // first hsync pixel
    localparam int HSN = 3;    // hsync width
    localparam int VSS = 9;    // first vsync line
    localparam int VSN = 2;    // vsync width
    localparam int K   = 1;
    localparam int BOX = 4;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] sel;

    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        hs0, vs0, bl0, fs0, hs1, vs1, bl1, fs1;
    logic [11:0] x0, x1;
    logic [10:0] y0, y1;
    logic [7:0]  fc0, fc1;

    always #5 clk = ~clk;

    vga_timing_pattern #(
        .C_resolution_x(RX), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
        .C_resolution_y(RY), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(1),
        .C_hsync_polarity(1'b0), .C_vsync_polarity(1'b0),
        .C_check_log2(K), .C_box(BOX), .C_bits_x(12), .C_bits_y(11)
    ) dut_p0 (
        .clk_pixel(clk), .reset(rst), .enable(enable), .pattern_sel(sel),
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0),
        .vga_blank(bl0), .x(x0), .y(y0), .frame_start(fs0), .frame_count(fc0)
    );

    vga_timing_pattern #(
        .C_resolution_x(RX), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
        .C_resolution_y(RY), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(1),
        .C_hsync_polarity(1'b1), .C_vsync_polarity(1'b1),
        .C_check_log2(K), .C_box(BOX), .C_bits_x(12), .C_bits_y(11)
    ) dut_p1 (
        .clk_pixel(clk), .reset(rst), .enable(enable), .pattern_sel(sel),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync(hs1), .vga_vsync(vs1),
        .vga_blank(bl1), .x(x1), .y(y1), .frame_start(fs1), .frame_count(fc1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: next raster position, frame index since reset,
    // and the pattern/enable latched for the frame in progress.
    int mx, my, nframe, pat_f;
    bit en_f;

    // Expected values for the pixel on the outputs after the latest edge
    logic [23:0] e_rgb;
    bit          e_blank, e_hs, e_vs, e_fs;
    int          e_x, e_y;
    logic [7:0]  e_fc;

    logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Box position of frame n: a triangle wave 0..m..0 with period 2m.
    function automatic int bounce_pos(input int n, input int m);
        int p;
        p = n % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction

    task automatic model_step();
        int bx, by;
        bit act;
        if (rst) begin
            e_rgb = '0; e_blank = 1'b1; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
            e_x = 0; e_y = 0; e_fc = '0;
            mx = 0; my = 0; nframe = -1; pat_f = 0; en_f = 1'b0;
            return;
        end
        if (mx == 0 && my == 0) begin
            nframe++;
            pat_f = int'(sel);
            en_f  = enable;
        end
        act     = (mx < RX) && (my < RY);
        e_x     = mx;
        e_y     = my;
        e_fs    = (mx == 0 && my == 0);
        e_fc    = 8'(nframe);
        e_blank = !act;
        e_hs    = (mx >= HSS) && (mx < HSS + HSN);
        e_vs    = (my >= VSS) && (my < VSS + VSN);
        e_rgb   = '0;
        if (act && en_f) begin
            case (pat_f)
                0: e_rgb = bar_colour[mx / (RX / 8)];
                1: e_rgb = ((((mx >> K) ^ (my >> K)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
                2: e_rgb = {8'(mx), 8'(my), 8'(nframe)};
                default: begin
                    bx = bounce_pos(nframe, RX - BOX);
                    by = bounce_pos(nframe, RY - BOX);
                    e_rgb = (mx >= bx && mx < bx + BOX && my >= by && my < by + BOX)
                            ? 24'hFFFFFF : 24'h000080;
                end
            endcase
        end
        mx++;
        if (mx == HT) begin
            mx = 0;
            my++;
            if (my == VT) my = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [10:0] ey;
        logic [11:0] ex;
        ex = 12'(e_x);
        ey = 11'(e_y);
        check("rgb_p0", 32'({r0, g0, b0}), 32'(e_rgb));
        check("rgb_p1", 32'({r1, g1, b1}), 32'(e_rgb));
        check("blank_fs_hs_vs_p0", 32'({bl0, fs0, hs0, vs0}), 32'({e_blank, e_fs, !e_hs, !e_vs}));
        check("blank_fs_hs_vs_p1", 32'({bl1, fs1, hs1, vs1}), 32'({e_blank, e_fs, e_hs, e_vs}));
        check("xy_p0", 32'({x0, y0}), 32'({ex, ey}));
        check("xy_p1", 32'({x1, y1}), 32'({ex, ey}));
        check("frame_count_p0", 32'(fc0), 32'(e_fc));
        check("frame_count_p1", 32'(fc1), 32'(e_fc));
    endtask

    // One pixel clock: model the edge, then compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (rnd) begin
                if ($urandom_range(63) == 0)  sel = 2'($urandom_range(3));
                if ($urandom_range(127) == 0) enable = ~enable;
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; enable = 1'b1; sel = 2'd0;
        mx = 0; my = 0; nframe = -1; pat_f = 0; en_f = 1'b0;
        run(3, 1'b0);                       // reset values held

        rst = 1'b0;                         // released on a falling edge
        run(2 * FRAME, 1'b0);               // bars, frames 0 and 1

        sel = 2'd1;                         // checker latched at frame 2
        run(100, 1'b0);
        sel = 2'd2;                         // mid-frame: frame 2 stays checker
        run(FRAME - 100 + 4 * FRAME, 1'b0); // gradient through frame 6

        sel = 2'd3;                         // box bounces in both axes
        run(20 * FRAME, 1'b0);

        run(5 * FRAME, 1'b1);               // random pattern/enable changes

        // Asynchronous reset in the middle of line 3.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle();
            found = (mx == 10 && my == 3);
        end
        check("reach_cx10_cy3", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rgb_p0", 32'({r0, g0, b0}), 32'd0);
        check("async_ctl_p0", 32'({bl0, fs0, hs0, vs0}), 32'b1011);
        check("async_ctl_p1", 32'({bl1, fs1, hs1, vs1}), 32'b1000);
        check("async_xy_fc_p0", 32'({x0, y0, fc0}), 32'd0);
        run(3, 1'b0);
        rst = 1'b0;

        run(258 * FRAME, 1'b1);             // long random run, frame_count wraps

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
